demux_16bit_1i2o_buf: RTL and testbench
=======================================

# demux_16bit_1i2o_buf

Buffered 1-to-2 demultiplexer: the write-side counterpart of the 2-input result mux in the accumulator datapath. It accepts one 16-bit word per cycle from a producer (ALU/accumulator write-back) with a select bit, and steers it into one of two output channels (A when `s`=0, B when `s`=1). Each channel has its own small FIFO and valid/ready handshake, so the two consumers (register bank, memory/output port) can stall independently. Per-channel word counters support debug and verification.

## Interface
Parameters:
- `WIDTH`, 16, data width.
- `DEPTH`, 2, entries per channel FIFO; power of two, ≥2.
- `CNT_W`, 8, width of the per-channel routed-word counters.

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  producer has a word.
- `in_ready`  out  1  word will be accepted this cycle.
- `s`  in  1  select: 0 → channel A, 1 → channel B; qualified by `in_valid`.
- `d`  in  WIDTH  input word.
- `a_valid`  out  1  channel A head valid.
- `a_ready`  in  1  consumer A takes head.
- `a`  out  WIDTH  channel A head word.
- `b_valid`, `b_ready`, `b`: same as A, for channel B.
- `cnt_a`  out  CNT_W  words accepted into A since reset, modulo 2^CNT_W.
- `cnt_b`  out  CNT_W  same for B.

## Operation
- Accept: `in_valid && in_ready` at a rising edge pushes `d` into the FIFO chosen by `s`.
- `in_ready` = NOT full(FIFO selected by current `s`). Combinational from `s` and FIFO state only; never from `in_valid`. Fullness of the other channel is irrelevant.
- Full FIFO: no push, even if that channel pops in the same cycle (no pass-through on full). Producer holds `d`/`s` stable until accepted.
- Pop: `x_valid && x_ready` at an edge removes the head of channel x. `x_ready` while empty is ignored.
- Simultaneous push and pop on one non-full, non-empty FIFO: both occur, occupancy unchanged.
- Push into an empty FIFO with pop the same cycle: pop is ignored (`x_valid` was 0), word enters.
- Output data: `a`/`b` = FIFO head when valid; 0 when empty.
- Order: strict FIFO per channel; no ordering relation between channels.
- Counters: increment by 1 on each accepted push into that channel; wrap 2^CNT_W−1 → 0.
- Pointers: read/write pointers of log2(DEPTH)+1 bits; full = MSBs differ and LSBs equal; empty = pointers equal; natural wrap.

## Timing
- Reset (async assert, any time including mid-transfer): FIFOs emptied, `a_valid`=`b_valid`=0, `a`=`b`=0, `cnt_a`=`cnt_b`=0, hence `in_ready`=1. Any in-flight data is discarded.
- Latency: a word accepted at edge N is visible on its channel with `x_valid`=1 from just after edge N (1 cycle) if the FIFO was empty.
- Throughput: 1 word/cycle sustained into either channel while its consumer holds ready high.
- `x_valid` stays high and `x` stays stable until popped.

## Structure
- Shared package `demux_pkg`: `WIDTH`=16 default, `CH_A`=1'b0, `CH_B`=1'b1 select encodings, pointer-width function `clog2`.
- One sub-module, `demux_fifo` (sync FIFO: push/pop/full/empty/head/data-zero-when-empty), instantiated twice. Top level holds select steering, `in_ready` logic and counters.

## Test plan
- Reset: drive `rst_n`=0 mid-burst with A holding 2 words → immediately `a_valid`=0, `a`=0, `cnt_a`=0, `in_ready`=1.
- Steering: push 0x1234 with `s`=0, then 0xABCD with `s`=1, consumers ready → 0x1234 on `a`, 0xABCD on `b`, one cycle after each accept; `cnt_a`=`cnt_b`=1.
- Backpressure/full: `a_ready`=0, push 0x0001, 0x0002, 0x0003 to A → first two accepted, `in_ready`=0 for third; switching `s`=1 raises `in_ready`; releasing `a_ready` yields 0x0001 then 0x0002.
- Full with same-cycle pop: A full, `a_ready`=1 and push to A same cycle → push refused that cycle, accepted next cycle; order preserved.
- Streaming: 300 consecutive words to B with `b_ready`=1 → one word per cycle out, in order, `cnt_b`=44 (300 mod 256).
- Independence: A stalled full, B streaming → B sees no bubbles for `s`=1 traffic.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared definitions for the buffered 1-to-2 write-back demultiplexer.
package demux_pkg;

    localparam int WIDTH = 16;

    // Select encodings for the s input
    localparam logic CH_A = 1'b0;
    localparam logic CH_B = 1'b1;

    // Ceiling log2, used to size FIFO pointers (constant-evaluated)
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < v) r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/demux_fifo.sv
// Small synchronous FIFO: pointers carry one extra wrap bit, head reads 0 when empty.
module demux_fifo #(
    parameter int WIDTH = demux_pkg::WIDTH,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);
    import demux_pkg::*;

    localparam int AW = clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    // Status and head word; head is forced to zero when nothing is stored
    always_comb begin
        empty = (wr_q == rd_q);
        full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
        head  = empty ? '0 : mem_q[rd_q[AW-1:0]];
    end

    // Next-state: a full FIFO refuses pushes, an empty one ignores pops
    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        mem_d = mem_q;
        if (push && !full) begin
            mem_d[wr_q[AW-1:0]] = wdata;
            wr_d = wr_q + PW'(1);
        end
        if (pop && !empty) begin
            rd_d = rd_q + PW'(1);
        end
    end

    // State registers; reset discards all stored words
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            mem_q <= mem_d;
        end
    end

endmodule

// File: rtl/demux_16bit_1i2o_buf.sv
// Buffered 1-to-2 demux: steers producer words into channel A or B FIFOs.
module demux_16bit_1i2o_buf #(
    parameter int WIDTH = demux_pkg::WIDTH,
    parameter int DEPTH = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             s,
    input  logic [WIDTH-1:0] d,
    output logic             a_valid,
    input  logic             a_ready,
    output logic [WIDTH-1:0] a,
    output logic             b_valid,
    input  logic             b_ready,
    output logic [WIDTH-1:0] b,
    output logic [CNT_W-1:0] cnt_a,
    output logic [CNT_W-1:0] cnt_b
);
    import demux_pkg::*;

    logic             a_full, a_empty, b_full, b_empty;
    logic             push_a, push_b, pop_a, pop_b;
    logic [CNT_W-1:0] cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;

    // Ready depends only on the selected channel's fullness, never on in_valid
    always_comb begin
        in_ready = (s == CH_B) ? !b_full : !a_full;
        push_a   = in_valid && in_ready && (s == CH_A);
        push_b   = in_valid && in_ready && (s == CH_B);
        a_valid  = !a_empty;
        b_valid  = !b_empty;
        pop_a    = a_valid && a_ready;
        pop_b    = b_valid && b_ready;
    end

    demux_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_a (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_a),
        .wdata (d),
        .pop   (pop_a),
        .full  (a_full),
        .empty (a_empty),
        .head  (a)
    );

    demux_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_b (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_b),
        .wdata (d),
        .pop   (pop_b),
        .full  (b_full),
        .empty (b_empty),
        .head  (b)
    );

    // Routed-word counters advance on each accepted push and wrap naturally
    always_comb begin
        cnt_a_d = push_a ? cnt_a_q + CNT_W'(1) : cnt_a_q;
        cnt_b_d = push_b ? cnt_b_q + CNT_W'(1) : cnt_b_q;
        cnt_a   = cnt_a_q;
        cnt_b   = cnt_b_q;
    end

    // Counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_a_q <= '0;
            cnt_b_q <= '0;
        end else begin
            cnt_a_q <= cnt_a_d;
            cnt_b_q <= cnt_b_d;
        end
    end

endmodule

// File: tb/tb_demux_16bit_1i2o_buf.sv
// Bench for the buffered demux: queue-based model checked every cycle plus directed literals.
module tb_demux_16bit_1i2o_buf;
    localparam int W = 16;
    localparam int DEPTH = 2;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          s = 1'b0;
    logic [W-1:0]  d = '0;
    logic          a_valid, b_valid;
    logic          a_ready = 1'b0, b_ready = 1'b0;
    logic [W-1:0]  a, b;
    logic [CW-1:0] cnt_a, cnt_b;

    int n_cmp = 0;
    int n_bad = 0;

    demux_16bit_1i2o_buf #(.WIDTH(W), .DEPTH(DEPTH), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .s(s), .d(d), .a_valid(a_valid), .a_ready(a_ready), .a(a),
        .b_valid(b_valid), .b_ready(b_ready), .b(b), .cnt_a(cnt_a), .cnt_b(cnt_b)
    );

    always #5 clk = ~clk;

    // Model: two queues of words plus accepted-word counts
    logic [W-1:0] qa[$];
    logic [W-1:0] qb[$];
    int           ma = 0, mb = 0;

    function automatic logic model_ready(input logic sel);
        return sel ? (qb.size() < DEPTH) : (qa.size() < DEPTH);
    endfunction

    always @(negedge rst_n) begin
        qa.delete(); qb.delete(); ma = 0; mb = 0;
    end

    always @(posedge clk) begin
        if (rst_n) begin
            logic acc;
            acc = in_valid && model_ready(s);
            if (qa.size() > 0 && a_ready) void'(qa.pop_front());
            if (qb.size() > 0 && b_ready) void'(qb.pop_front());
            if (acc && !s) begin qa.push_back(d); ma = (ma + 1) % 256; end
            if (acc && s)  begin qb.push_back(d); mb = (mb + 1) % 256; end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Continuous comparison against the model away from the active edge
    always @(negedge clk) begin
        chk("m_a_valid", 32'(a_valid), 32'(qa.size() > 0));
        chk("m_b_valid", 32'(b_valid), 32'(qb.size() > 0));
        chk("m_a", 32'(a), 32'(qa.size() > 0 ? qa[0] : 16'h0));
        chk("m_b", 32'(b), 32'(qb.size() > 0 ? qb[0] : 16'h0));
        chk("m_cnt_a", 32'(cnt_a), 32'(ma));
        chk("m_cnt_b", 32'(cnt_b), 32'(mb));
        chk("m_in_ready", 32'(in_ready), 32'(model_ready(s)));
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    initial begin
        #12 rst_n = 1'b1;
        step();
        // Reset state
        chk("rst_a_valid", 32'(a_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_cnt_a", 32'(cnt_a), 32'd0);

        // Steering
        a_ready = 1; b_ready = 1;
        in_valid = 1; s = 0; d = 16'h1234;
        step();
        chk("steer_a", 32'(a), 32'h1234);
        chk("steer_a_valid", 32'(a_valid), 32'd1);
        s = 1; d = 16'hABCD;
        step();
        in_valid = 0;
        chk("steer_b", 32'(b), 32'hABCD);
        chk("steer_a_popped", 32'(a_valid), 32'd0);
        chk("steer_cnt_a", 32'(cnt_a), 32'd1);
        chk("steer_cnt_b", 32'(cnt_b), 32'd1);
        step();

        // Backpressure: third push to A refused, other select is ready
        a_ready = 0; b_ready = 0;
        in_valid = 1; s = 0; d = 16'h0001; step();
        d = 16'h0002; step();
        d = 16'h0003;
        chk("full_in_ready", 32'(in_ready), 32'd0);
        s = 1; #1;
        chk("other_in_ready", 32'(in_ready), 32'd1);
        s = 0; in_valid = 0; a_ready = 1; #1;
        chk("bp_head1", 32'(a), 32'h0001);
        step();
        chk("bp_head2", 32'(a), 32'h0002);
        step();
        chk("bp_empty", 32'(a_valid), 32'd0);

        // Full with same-cycle pop: push refused, taken next cycle, order kept
        a_ready = 0; in_valid = 1; s = 0;
        d = 16'h0010; step();
        d = 16'h0011; step();
        a_ready = 1; d = 16'h0012;
        chk("fp_in_ready", 32'(in_ready), 32'd0);
        step();
        chk("fp_head", 32'(a), 32'h0011);
        chk("fp_ready_again", 32'(in_ready), 32'd1);
        step();
        in_valid = 0;
        chk("fp_late", 32'(a), 32'h0012);
        chk("fp_cnt_a", 32'(cnt_a), 32'd6);
        step();

        // Stall A full, then stream 300 words into B with no bubbles
        a_ready = 0; in_valid = 1; s = 0;
        d = 16'h00A0; step();
        d = 16'h00A1; step();
        s = 1; b_ready = 1;
        for (int i = 0; i < 300; i++) begin
            d = 16'(16'h0100 + i);
            step();
            chk("stream_b", 32'(b), 32'(16'h0100 + i));
            chk("stream_b_valid", 32'(b_valid), 32'd1);
        end
        in_valid = 0;
        chk("stream_a_held", 32'(a), 32'h00A0);
        // One earlier word plus 300 streamed: 301 mod 256
        chk("stream_cnt_b", 32'(cnt_b), 32'd45);
        chk("stream_cnt_a", 32'(cnt_a), 32'd8);
        step();

        // Async reset while A holds two words
        #1 rst_n = 0;
        #1;
        chk("mid_rst_a_valid", 32'(a_valid), 32'd0);
        chk("mid_rst_a", 32'(a), 32'd0);
        chk("mid_rst_cnt_a", 32'(cnt_a), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        #1 rst_n = 1;
        step();
        in_valid = 1; s = 0; d = 16'h5555; step();
        in_valid = 0;
        chk("post_rst_a", 32'(a), 32'h5555);
        step(); step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
